// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a ready/load handshake and registered q/qbar, frame and done.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             qbar,
    output logic             frame,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_qbar;
    logic             r_ready;
    logic             r_frame;
    logic             r_done;
`ifdef PISO_TX_PARITY_EN
    logic             r_par;
`endif
    logic             w_accept;
    logic             w_first_bit;
    logic             w_next_bit;
    logic             w_q_nxt;
    logic             w_frame_nxt;
    logic             w_ready_nxt;
    logic             w_done_nxt;

    assign w_accept    = load && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_first_bit = (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
    // r_sr still holds the current bit at its head, so the one after it is the next to send
    assign w_next_bit  = (MSB_FIRST != 0) ? r_sr[WIDTH-2] : r_sr[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sr  <= d;
                r_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
                r_par <= ^d;
`endif
            end else if (r_state == S_SHIFT) begin
                r_sr  <= (MSB_FIRST != 0) ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (load) w_state_nxt = S_SHIFT;
`ifdef PISO_TX_PARITY_EN
            S_SHIFT:  if (r_cnt == CNT_LAST) w_state_nxt = S_PARITY;
            S_PARITY: w_state_nxt = S_DONE;
`else
            S_SHIFT:  if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
`endif
            S_DONE:   w_state_nxt = load ? S_SHIFT : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without a cycle of lag
    always_comb begin
        w_q_nxt     = 1'b0;
        w_frame_nxt = 1'b0;
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_ready_nxt = 1'b1;
            S_SHIFT: begin
                w_frame_nxt = 1'b1;
                w_q_nxt     = (r_state == S_SHIFT) ? w_next_bit : w_first_bit;
            end
`ifdef PISO_TX_PARITY_EN
            S_PARITY: begin
                w_frame_nxt = 1'b1;
                w_q_nxt     = r_par;
            end
`endif
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_ready_nxt = 1'b1;
            end
            default: w_ready_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= 1'b0;
            r_qbar  <= 1'b1;
            r_ready <= 1'b1;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_qbar  <= ~w_q_nxt;
            r_ready <= w_ready_nxt;
            r_frame <= w_frame_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q     = r_q;
    assign qbar  = r_qbar;
    assign ready = r_ready;
    assign frame = r_frame;
    assign done  = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus; a timeline model
// predicts every output cycle into a scoreboard queue that a negedge monitor drains.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] d;
    logic ready_m, q_m, qbar_m, frame_m, done_m;
    logic ready_l, q_l, qbar_l, frame_l, done_l;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .d(d), .load(load),
        .ready(ready_m), .q(q_m), .qbar(qbar_m), .frame(frame_m), .done(done_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .load(load),
        .ready(ready_l), .q(q_l), .qbar(qbar_l), .frame(frame_l), .done(done_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic qm;
        logic ql;
        logic frame;
        logic done;
        logic ready;
    } obs_t;

    localparam obs_t IDLE_OBS = '{qm: 1'b0, ql: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b1};

    obs_t tl[$];
    obs_t expq[$];
    obs_t cur;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one edge and predict the cycle that follows it
    task automatic step(input logic r, input logic l, input logic [W-1:0] dv);
        rst  = r;
        load = l;
        d    = dv;
        @(posedge clk);
        if (r) begin
            tl.delete();
            cur = IDLE_OBS;
        end else begin
            if (l && cur.ready) begin
                for (int i = 0; i < W; i++)
                    tl.push_back('{qm: dv[W-1-i], ql: dv[i], frame: 1'b1, done: 1'b0, ready: 1'b0});
`ifdef PISO_TX_PARITY_EN
                tl.push_back('{qm: ^dv, ql: ^dv, frame: 1'b1, done: 1'b0, ready: 1'b0});
`endif
                tl.push_back('{qm: 1'b0, ql: 1'b0, frame: 1'b0, done: 1'b1, ready: 1'b1});
            end
            if (tl.size() > 0) cur = tl.pop_front();
            else               cur = IDLE_OBS;
        end
        expq.push_back(cur);
        #2;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("q_msb",     q_m,     e.qm);
                chk("qbar_msb",  qbar_m,  ~e.qm);
                chk("frame_msb", frame_m, e.frame);
                chk("done_msb",  done_m,  e.done);
                chk("ready_msb", ready_m, e.ready);
                chk("q_lsb",     q_l,     e.ql);
                chk("qbar_lsb",  qbar_l,  ~e.ql);
                chk("frame_lsb", frame_l, e.frame);
                chk("done_lsb",  done_l,  e.done);
                chk("ready_lsb", ready_l, e.ready);
            end
        end
    end

    initial begin : driver
        int flen;
`ifdef PISO_TX_PARITY_EN
        flen = W + 1;
`else
        flen = W;
`endif
        cur  = IDLE_OBS;
        rst  = 1'b1;
        load = 1'b0;
        d    = '0;

        repeat (2) step(1'b1, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, '0);

        // Directed single frames: A5, 01, 07
        step(1'b0, 1'b1, 8'hA5);
        repeat (flen + 3) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        repeat (flen + 3) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h07);
        repeat (flen + 3) step(1'b0, 1'b0, 8'h00);

        // Busy load held high: 0F must only be taken in the DONE cycle
        step(1'b0, 1'b1, 8'hF0);
        repeat (flen + 1) step(1'b0, 1'b1, 8'h0F);
        repeat (flen + 3) step(1'b0, 1'b0, 8'h00);

        // Reset after three bits of FF; no done may follow
        step(1'b0, 1'b1, 8'hFF);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        repeat (flen + 3) step(1'b0, 1'b0, 8'h00);

        // Reset and load together: reset wins
        step(1'b1, 1'b1, 8'hC3);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), W'($urandom));

        repeat (3) step(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
